// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO one byte at a time and
// serialises each byte LSB-first onto the TX pin as an 8N1 frame.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
// The FSM state is exported on dbg_state_o for checker binding.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [2:0] dbg_state_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    // FIFO handshake: fifo_empty=0 means a byte is available; one
    // fifo_rd_en cycle (a pure decode of FETCH) pops it, and the FIFO
    // presents the byte on fifo_data one cycle later, where LOAD samples it.
    // fifo_empty is only looked at in IDLE, so a frame is never interrupted.
    assign fifo_rd_en  = (state_q == S_FETCH);
    assign busy        = (state_q != S_IDLE);
    assign tx          = tx_q;
    assign tx_done     = done_q;
    assign dbg_state_o = state_q;
    assign bit_end     = (cnt_q == LAST);

`ifdef UART_TX_PARITY_EN
    logic par_q;

    // Even parity of the byte being sent, captured alongside the shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            par_q <= ^fifo_data;
        end
    end
`endif

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx_d is the line level of the state being entered,
    // so the pin changes on the same edge as the state and never glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_data;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
